core_bus_ctrl: RTL and testbench
================================

// Module: core_bus_ctrl
// PURPOSE
//  External memory bus sequencer directly downstream of core_mem_ctrl.
//  - Converts its ext ROM read / ext RAM read / ext RAM write strobes into a
//    multiplexed 8051-style pad cycle: P0 = addr low / data, P2 = addr high.
//  - Drives ALE, PSEN_b, RD_b and WR_b, and returns read data plus a one-cycle ready.
//  - Synchronises the EA_b pad and feeds it back to core_mem_ctrl.
// PARAMETERS
//  STROBE_CYCLES  2  cycles PSEN_b/RD_b/WR_b are held low; legal range 1..15
// PORTS
//  bus_ctrl_clk_i           in   1   core clock
//  bus_ctrl_rst_i           in   1   reset, asynchronous, active-high
//  bus_ctrl_ext_rom_rd_b_i  in   1   ext ROM read request, active-low, level
//  bus_ctrl_ext_ram_rd_b_i  in   1   ext RAM read request, active-low, level
//  bus_ctrl_ext_ram_wr_b_i  in   1   ext RAM write request, active-low, level
//  bus_ctrl_addr_i          in   16  transaction address
//  bus_ctrl_data_i          in   8   write data from core_mem_ctrl
//  bus_ctrl_data_o          out  8   read data to core_mem_ctrl (registered)
//  bus_ctrl_ready_o         out  1   one-cycle pulse: transaction complete
//  bus_ctrl_ea_pad_b_i      in   1   EA_b pad, asynchronous
//  bus_ctrl_ea_b_o          out  1   synchronised EA_b to core_mem_ctrl
//  bus_ctrl_p0_i            in   8   P0 pad input
//  bus_ctrl_p0_o            out  8   P0 pad output
//  bus_ctrl_p0_oe_o         out  1   P0 output enable, 1 = drive
//  bus_ctrl_p2_o            out  8   P2 pad output (addr[15:8])
//  bus_ctrl_ale_o           out  1   address latch enable, active-high
//  bus_ctrl_psen_b_o        out  1   program store enable, active-low
//  bus_ctrl_rd_b_o          out  1   ext RAM read strobe, active-low
//  bus_ctrl_wr_b_o          out  1   ext RAM write strobe, active-low
// BEHAVIOUR
//  Reset values
//  - data_o = 8'h00, ready = 0, p0_o = p2_o = 8'h00, p0_oe = 0, ale = 0.
//  - psen_b = rd_b = wr_b = 1. ea_b_o = 1 (both sync flops reset to 1).
//  - State = IDLE, strobe counter = 0.
//  Reset asserted mid-transaction: all of the above take effect immediately
//  (asynchronously); the in-flight transaction is dropped with no ready.
//  Request arbitration (IDLE only)
//  - Requests are sampled each cycle; priority is wr > ram_rd > rom_rd.
//  - Addr, write data and kind are latched; lower-priority requests are ignored.
//  FSM, with N = STROBE_CYCLES:
//  - IDLE: request seen -> ADDR.
//  - ADDR (1 cycle): ale = 1, p0_o = addr[7:0], p0_oe = 1, p2_o = addr[15:8].
//  - HOLD (1 cycle): ale = 0, P0 keeps addr (hold time).
//  - STRB (N cycles): selected strobe low.
//      Write: p0_o = wdata, p0_oe = 1.
//      Read: p0_oe = 0.
//      On the last STRB edge a read captures p0_i into data_o.
//  - END (1 cycle): strobes high, ready = 1.
//      Write: P0 keeps wdata (hold); p0_oe drops on exit. Then -> IDLE.
//  Latency and data validity
//  - Request visible in IDLE at cycle 0 -> ready in cycle 3+N; 4+N cycles per access.
//  - data_o is valid from the END cycle and held until the next read completes;
//    writes never change data_o.
//  Handshake
//  - The requester samples ready and must change or deassert its strobe in the
//    ready cycle.
//  - A strobe still low in the IDLE cycle after END starts a new transaction
//    (back-to-back fetch).
//  - p2_o retains the last address between transactions.
//  Other rules
//  - Exactly one of psen_b/rd_b/wr_b is low at any time, only in STRB.
//  - ale is never high in the same cycle as any strobe.
//  - EA_b: two-flop synchroniser, 2-cycle latency, independent of the FSM.
//  - The counter is 4 bits; N = 1 means a single STRB cycle.
// STRUCTURE
//  core_defines.vh (shared include):
//  - FSM state encodings IDLE/ADDR/HOLD/STRB/END.
//  - Transaction kind codes ROM_RD/RAM_RD/RAM_WR.
//  - Constants ENABLE = 1'b0, DISABLE = 1'b1.
//  Sub-module core_bus_ctrl_sync: two-flop synchroniser with reset value 1,
//  used for EA_b.
//  Top level holds the FSM, counter, latched addr/wdata/kind and the data_o register.
// TESTING
//  1. Reset: hold rst 3 cycles with random pads -> every output at its reset value;
//     ea_b_o = 1.
//  2. ROM read, N = 2: rom_rd_b = 0, addr = 16'hA55A, p0_i = 8'h3C ->
//     ale high for 1 cycle with p0_o = 8'h5A, p2_o = 8'hA5; psen_b low 2 cycles;
//     ready at cycle 5; data_o = 8'h3C.
//  3. RAM write: wr_b = 0, addr = 16'h0012, data = 8'hC3 ->
//     wr_b low 2 cycles with p0_oe = 1 and p0_o = 8'hC3 through END;
//     data_o unchanged; psen_b and rd_b stay 1.
//  4. Simultaneous wr and rom_rd requests -> only wr_b pulses;
//     rom_rd is served next after wr_b is deasserted.
//  5. Back-to-back ROM fetch, addr 16'hFFFE to 16'hFFFF, holding rom_rd_b low ->
//     two transactions 6 cycles apart; correct data each time; p2_o stays 8'hFF.
//  6. Assert rst in the 2nd STRB cycle of a read -> rd_b = 1 and p0_oe = 0
//     immediately; no ready; data_o = 8'h00.
//     Also toggle ea_pad_b -> ea_b_o follows after 2 edges.

Source files
------------

// File: rtl/core_bus_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// core_bus_ctrl_pkg
// Shared definitions for the external memory bus sequencer.
//   - bus_state_e : sequencer states IDLE/ADDR/HOLD/STRB/END
//   - bus_kind_e  : transaction kinds ROM_RD/RAM_RD/RAM_WR
//   - ENABLE / DISABLE : levels for the active-low pad strobes and requests
//   - any_request / pick_kind : request decode and fixed-priority arbitration
// No ports (package only).
// -----------------------------------------------------------------------------
package core_bus_ctrl_pkg;

  // Sequencer states. Each pad cycle walks ADDR -> HOLD -> STRB(xN) -> END.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_HOLD = 3'd2,
    ST_STRB = 3'd3,
    ST_END  = 3'd4
  } bus_state_e;

  // Kind of the latched transaction; selects which strobe pulses in STRB.
  typedef enum logic [1:0] {
    KIND_ROM_RD = 2'd0,
    KIND_RAM_RD = 2'd1,
    KIND_RAM_WR = 2'd2
  } bus_kind_e;

  // Strobes and requests on this bus are active-low.
  localparam logic ENABLE  = 1'b0;
  localparam logic DISABLE = 1'b1;

  // Width of the strobe-length counter; allows STROBE_CYCLES up to 15.
  localparam int CNT_W = 4;

  // True when any of the three request strobes is asserted.
  function automatic logic any_request(input logic rom_rd_b,
                                       input logic ram_rd_b,
                                       input logic ram_wr_b);
    return (rom_rd_b == ENABLE) || (ram_rd_b == ENABLE) || (ram_wr_b == ENABLE);
  endfunction

  // Fixed priority: write beats RAM read beats ROM read.
  function automatic bus_kind_e pick_kind(input logic ram_rd_b,
                                          input logic ram_wr_b);
    bus_kind_e kind;
    if (ram_wr_b == ENABLE) begin
      kind = KIND_RAM_WR;
    end else if (ram_rd_b == ENABLE) begin
      kind = KIND_RAM_RD;
    end else begin
      kind = KIND_ROM_RD;
    end
    return kind;
  endfunction

endpackage

// File: rtl/core_bus_ctrl_sync.sv
// -----------------------------------------------------------------------------
// core_bus_ctrl_sync
// Two-flop synchroniser for a single asynchronous pad level. Both flops reset
// to 1 so an active-low pad reads as inactive until it has been sampled.
// Ports:
//   clk  in  1  destination clock
//   rst  in  1  asynchronous active-high reset
//   din  in  1  asynchronous input level
//   dout out 1  synchronised level, two clock edges behind din
// -----------------------------------------------------------------------------
module core_bus_ctrl_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta_q;
  logic sync_q;

  // First flop may go metastable; the second gives it a full cycle to settle
  // before anything downstream looks at the value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
    end
  end

  assign dout = sync_q;

endmodule

// File: rtl/core_bus_ctrl.sv
// -----------------------------------------------------------------------------
// core_bus_ctrl
// External memory bus sequencer sitting behind core_mem_ctrl. Turns a level
// request (ext ROM read, ext RAM read, ext RAM write) into a multiplexed
// 8051-style pad cycle: ALE with the low address on P0 and high address on P2,
// a hold cycle, STROBE_CYCLES of PSEN_b/RD_b/WR_b low, then an END cycle that
// pulses ready. Read data is captured from P0 on the last strobe edge.
// EA_b is synchronised independently of the sequencer.
// Parameters:
//   STROBE_CYCLES  cycles the selected strobe is held low (1..15)
// Ports:
//   bus_ctrl_clk_i           in   1   core clock
//   bus_ctrl_rst_i           in   1   asynchronous active-high reset
//   bus_ctrl_ext_rom_rd_b_i  in   1   ext ROM read request, active-low level
//   bus_ctrl_ext_ram_rd_b_i  in   1   ext RAM read request, active-low level
//   bus_ctrl_ext_ram_wr_b_i  in   1   ext RAM write request, active-low level
//   bus_ctrl_addr_i          in   16  transaction address
//   bus_ctrl_data_i          in   8   write data
//   bus_ctrl_data_o          out  8   registered read data
//   bus_ctrl_ready_o         out  1   one-cycle transaction-complete pulse
//   bus_ctrl_ea_pad_b_i      in   1   EA_b pad (asynchronous)
//   bus_ctrl_ea_b_o          out  1   synchronised EA_b
//   bus_ctrl_p0_i            in   8   P0 pad input
//   bus_ctrl_p0_o            out  8   P0 pad output
//   bus_ctrl_p0_oe_o         out  1   P0 output enable (1 = drive)
//   bus_ctrl_p2_o            out  8   P2 pad output (address high byte)
//   bus_ctrl_ale_o           out  1   address latch enable, active-high
//   bus_ctrl_psen_b_o        out  1   program store enable, active-low
//   bus_ctrl_rd_b_o          out  1   RAM read strobe, active-low
//   bus_ctrl_wr_b_o          out  1   RAM write strobe, active-low
// -----------------------------------------------------------------------------
module core_bus_ctrl
  import core_bus_ctrl_pkg::*;
#(
  parameter int STROBE_CYCLES = 2
) (
  input  logic        bus_ctrl_clk_i,
  input  logic        bus_ctrl_rst_i,
  input  logic        bus_ctrl_ext_rom_rd_b_i,
  input  logic        bus_ctrl_ext_ram_rd_b_i,
  input  logic        bus_ctrl_ext_ram_wr_b_i,
  input  logic [15:0] bus_ctrl_addr_i,
  input  logic [7:0]  bus_ctrl_data_i,
  output logic [7:0]  bus_ctrl_data_o,
  output logic        bus_ctrl_ready_o,
  input  logic        bus_ctrl_ea_pad_b_i,
  output logic        bus_ctrl_ea_b_o,
  input  logic [7:0]  bus_ctrl_p0_i,
  output logic [7:0]  bus_ctrl_p0_o,
  output logic        bus_ctrl_p0_oe_o,
  output logic [7:0]  bus_ctrl_p2_o,
  output logic        bus_ctrl_ale_o,
  output logic        bus_ctrl_psen_b_o,
  output logic        bus_ctrl_rd_b_o,
  output logic        bus_ctrl_wr_b_o
);

  // Counter value seen during the final STRB cycle.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STROBE_CYCLES - 1);

  bus_state_e       state_q;
  bus_state_e       state_d;
  bus_kind_e        kind_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      addr_q;
  logic [7:0]       wdata_q;
  logic [7:0]       data_q;
  logic             req_any;
  logic             strb_last;

  assign req_any   = any_request(bus_ctrl_ext_rom_rd_b_i,
                                 bus_ctrl_ext_ram_rd_b_i,
                                 bus_ctrl_ext_ram_wr_b_i);
  assign strb_last = (cnt_q == LAST_CNT);

  // State register. Reset drops any in-flight transaction without a ready.
  always_ff @(posedge bus_ctrl_clk_i or posedge bus_ctrl_rst_i) begin
    if (bus_ctrl_rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and pad decode. Every pad output is a pure function of the
  // state and latched transaction, so an asynchronous reset of those flops
  // returns the pads to idle levels immediately.
  always_comb begin
    state_d           = state_q;
    bus_ctrl_ale_o    = 1'b0;
    bus_ctrl_psen_b_o = DISABLE;
    bus_ctrl_rd_b_o   = DISABLE;
    bus_ctrl_wr_b_o   = DISABLE;
    bus_ctrl_p0_o     = 8'h00;
    bus_ctrl_p0_oe_o  = 1'b0;
    bus_ctrl_ready_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        bus_ctrl_ale_o   = 1'b1;
        bus_ctrl_p0_o    = addr_q[7:0];
        bus_ctrl_p0_oe_o = 1'b1;
        state_d          = ST_HOLD;
      end
      ST_HOLD: begin
        // ALE has fallen; the low address stays on P0 for latch hold time.
        bus_ctrl_p0_o    = addr_q[7:0];
        bus_ctrl_p0_oe_o = 1'b1;
        state_d          = ST_STRB;
      end
      ST_STRB: begin
        case (kind_q)
          KIND_ROM_RD: bus_ctrl_psen_b_o = ENABLE;
          KIND_RAM_RD: bus_ctrl_rd_b_o   = ENABLE;
          KIND_RAM_WR: begin
            bus_ctrl_wr_b_o  = ENABLE;
            bus_ctrl_p0_o    = wdata_q;
            bus_ctrl_p0_oe_o = 1'b1;
          end
          default: ;
        endcase
        if (strb_last) begin
          state_d = ST_END;
        end
      end
      ST_END: begin
        bus_ctrl_ready_o = 1'b1;
        // Writes keep data on P0 one more cycle after WR_b rises.
        if (kind_q == KIND_RAM_WR) begin
          bus_ctrl_p0_o    = wdata_q;
          bus_ctrl_p0_oe_o = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobe-length counter: counts STRB cycles, parked at zero elsewhere so it
  // always starts from zero on entry to STRB.
  always_ff @(posedge bus_ctrl_clk_i or posedge bus_ctrl_rst_i) begin
    if (bus_ctrl_rst_i) begin
      cnt_q <= '0;
    end else if (state_q == ST_STRB) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  // Transaction latch. Only taken in IDLE; the address is kept afterwards so
  // P2 continues to show the last address between transactions.
  always_ff @(posedge bus_ctrl_clk_i or posedge bus_ctrl_rst_i) begin
    if (bus_ctrl_rst_i) begin
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      kind_q  <= KIND_ROM_RD;
    end else if ((state_q == ST_IDLE) && req_any) begin
      addr_q  <= bus_ctrl_addr_i;
      wdata_q <= bus_ctrl_data_i;
      kind_q  <= pick_kind(bus_ctrl_ext_ram_rd_b_i, bus_ctrl_ext_ram_wr_b_i);
    end
  end

  // Read data register: sampled from P0 on the edge that ends the last STRB
  // cycle, then held until the next read completes. Writes leave it alone.
  always_ff @(posedge bus_ctrl_clk_i or posedge bus_ctrl_rst_i) begin
    if (bus_ctrl_rst_i) begin
      data_q <= 8'h00;
    end else if ((state_q == ST_STRB) && strb_last && (kind_q != KIND_RAM_WR)) begin
      data_q <= bus_ctrl_p0_i;
    end
  end

  assign bus_ctrl_data_o = data_q;
  assign bus_ctrl_p2_o   = addr_q[15:8];

  // EA_b is a static strap on the pad; it only needs synchronising.
  core_bus_ctrl_sync u_ea_sync (
    .clk  (bus_ctrl_clk_i),
    .rst  (bus_ctrl_rst_i),
    .din  (bus_ctrl_ea_pad_b_i),
    .dout (bus_ctrl_ea_b_o)
  );

endmodule

// File: tb/tb_core_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_core_bus_ctrl
// Self-checking bench for core_bus_ctrl. A cycle-level reference model tracks
// each transaction by its cycle offset from the accepting IDLE cycle and
// predicts every pad output; directed scenarios cover the documented cases,
// followed by a randomized requester that obeys the ready handshake.
// -----------------------------------------------------------------------------
module tb_core_bus_ctrl;

  localparam int N       = 2;
  localparam int K_ROM   = 0;
  localparam int K_RAMRD = 1;
  localparam int K_WR    = 2;

  logic        clk;
  logic        rst;
  logic        rom_b;
  logic        ram_rd_b;
  logic        wr_b;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  p0_in;
  logic        ea_pad;
  logic [7:0]  data_o;
  logic        ready;
  logic        ea_b;
  logic [7:0]  p0_o;
  logic        p0_oe;
  logic [7:0]  p2_o;
  logic        ale;
  logic        psen_b;
  logic        rd_b;
  logic        wr_b_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_busy;
  int          m_off;
  int          m_kind;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata;
  logic [7:0]  m_data;
  logic [7:0]  m_p2;
  logic [1:0]  m_ea_hist;
  logic        exp_ready;
  bit          pending;

  core_bus_ctrl #(.STROBE_CYCLES(N)) dut (
    .bus_ctrl_clk_i          (clk),
    .bus_ctrl_rst_i          (rst),
    .bus_ctrl_ext_rom_rd_b_i (rom_b),
    .bus_ctrl_ext_ram_rd_b_i (ram_rd_b),
    .bus_ctrl_ext_ram_wr_b_i (wr_b),
    .bus_ctrl_addr_i         (addr),
    .bus_ctrl_data_i         (wdata),
    .bus_ctrl_data_o         (data_o),
    .bus_ctrl_ready_o        (ready),
    .bus_ctrl_ea_pad_b_i     (ea_pad),
    .bus_ctrl_ea_b_o         (ea_b),
    .bus_ctrl_p0_i           (p0_in),
    .bus_ctrl_p0_o           (p0_o),
    .bus_ctrl_p0_oe_o        (p0_oe),
    .bus_ctrl_p2_o           (p2_o),
    .bus_ctrl_ale_o          (ale),
    .bus_ctrl_psen_b_o       (psen_b),
    .bus_ctrl_rd_b_o         (rd_b),
    .bus_ctrl_wr_b_o         (wr_b_o)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something stalls the main sequence.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point; every check is counted here.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic modelReset();
    m_busy    = 1'b0;
    m_off     = 0;
    m_kind    = K_ROM;
    m_addr    = 16'h0000;
    m_wdata   = 8'h00;
    m_data    = 8'h00;
    m_p2      = 8'h00;
    m_ea_hist = 2'b11;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  // A transaction lives for offsets 1..3+N after the IDLE cycle that saw it.
  task automatic modelEdge();
    if (rst) begin
      modelReset();
      return;
    end
    m_ea_hist = {m_ea_hist[0], ea_pad};
    if (!m_busy) begin
      if (!wr_b || !ram_rd_b || !rom_b) begin
        m_busy  = 1'b1;
        m_off   = 1;
        m_addr  = addr;
        m_wdata = wdata;
        m_p2    = addr[15:8];
        if (!wr_b)          m_kind = K_WR;
        else if (!ram_rd_b) m_kind = K_RAMRD;
        else                m_kind = K_ROM;
      end
    end else if (m_off == 3 + N) begin
      m_busy = 1'b0;
    end else begin
      if ((m_off == 2 + N) && (m_kind != K_WR)) m_data = p0_in;
      m_off++;
    end
  endtask

  // Compare every DUT output against what the model predicts for this cycle.
  task automatic compareAll();
    bit         in_strb;
    logic       e_oe;
    logic [7:0] e_p0;
    in_strb   = m_busy && (m_off >= 3) && (m_off <= 2 + N);
    e_oe      = m_busy && ((m_off <= 2) || (m_kind == K_WR));
    e_p0      = (m_off <= 2) ? m_addr[7:0] : m_wdata;
    exp_ready = m_busy && (m_off == 3 + N);
    checkOutput("ale",    32'(ale),    32'(m_busy && (m_off == 1)));
    checkOutput("ready",  32'(ready),  32'(exp_ready));
    checkOutput("psen_b", 32'(psen_b), 32'(!(in_strb && (m_kind == K_ROM))));
    checkOutput("rd_b",   32'(rd_b),   32'(!(in_strb && (m_kind == K_RAMRD))));
    checkOutput("wr_b",   32'(wr_b_o), 32'(!(in_strb && (m_kind == K_WR))));
    checkOutput("p0_oe",  32'(p0_oe),  32'(e_oe));
    if (e_oe) checkOutput("p0_o", 32'(p0_o), 32'(e_p0));
    checkOutput("p2_o",   32'(p2_o),   32'(m_p2));
    checkOutput("data_o", 32'(data_o), 32'(m_data));
    checkOutput("ea_b",   32'(ea_b),   32'(m_ea_hist[1]));
  endtask

  // One clock with the currently applied inputs, then a full output check at
  // the following falling edge.
  task automatic applyStimulus();
    modelEdge();
    @(posedge clk);
    @(negedge clk);
    compareAll();
  endtask

  // Run until the DUT signals ready (bounded), counting pad activity.
  task automatic runUntilReady(output int cyc, output int psen_lo,
                               output int rd_lo, output int wr_lo,
                               output int ale_hi);
    cyc = 0; psen_lo = 0; rd_lo = 0; wr_lo = 0; ale_hi = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      cyc++;
      if (psen_b === 1'b0) psen_lo++;
      if (rd_b === 1'b0)   rd_lo++;
      if (wr_b_o === 1'b0) wr_lo++;
      if (ale === 1'b1)    ale_hi++;
      if (ready === 1'b1) break;
    end
    if (ready !== 1'b1) checkOutput("ready_timeout", 32'd0, 32'd1);
  endtask

  // Random requester: holds a request until ready, may swap it in the ready
  // cycle, and jitters the pads every cycle.
  task automatic driveRandom();
    logic [2:0] mask;
    p0_in = 8'($urandom);
    if ($urandom_range(0, 3) == 0) ea_pad = ~ea_pad;
    if (exp_ready) begin
      pending  = 1'b0;
      rom_b    = 1'b1;
      ram_rd_b = 1'b1;
      wr_b     = 1'b1;
    end
    if (!pending && ($urandom_range(0, 2) == 0)) begin
      mask     = 3'($urandom_range(1, 7));
      wr_b     = ~mask[2];
      ram_rd_b = ~mask[1];
      rom_b    = ~mask[0];
      addr     = 16'($urandom);
      wdata    = 8'($urandom);
      pending  = 1'b1;
    end else if (!pending) begin
      addr  = 16'($urandom);
      wdata = 8'($urandom);
    end
  endtask

  initial begin
    int cyc, psen_lo, rd_lo, wr_lo, ale_hi;
    rst = 1'b1; rom_b = 1'b1; ram_rd_b = 1'b1; wr_b = 1'b1;
    addr = 16'h0000; wdata = 8'h00; p0_in = 8'h00; ea_pad = 1'b1;
    pending = 1'b0; exp_ready = 1'b0;
    modelReset();

    // Reset held with random pads: every output at its reset value.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      p0_in    = 8'($urandom);
      ea_pad   = 1'($urandom);
      rom_b    = 1'($urandom);
      ram_rd_b = 1'($urandom);
      wr_b     = 1'($urandom);
      addr     = 16'($urandom);
      applyStimulus();
      checkOutput("rst_ea_b", 32'(ea_b), 32'd1);
    end
    rom_b = 1'b1; ram_rd_b = 1'b1; wr_b = 1'b1; ea_pad = 1'b1; rst = 1'b0;
    applyStimulus();
    applyStimulus();

    // ROM read at A55A returning 3C.
    $display("[TB] ROM read");
    rom_b = 1'b0; addr = 16'hA55A; p0_in = 8'h3C;
    runUntilReady(cyc, psen_lo, rd_lo, wr_lo, ale_hi);
    checkOutput("rom_latency", 32'(cyc), 32'(3 + N));
    checkOutput("rom_psen_cycles", 32'(psen_lo), 32'(N));
    checkOutput("rom_ale_cycles", 32'(ale_hi), 32'd1);
    checkOutput("rom_data", 32'(data_o), 32'h3C);
    rom_b = 1'b1;
    applyStimulus();

    // RAM write of C3 to 0012; data_o must keep the previous read.
    $display("[TB] RAM write");
    wr_b = 1'b0; addr = 16'h0012; wdata = 8'hC3; p0_in = 8'hEE;
    runUntilReady(cyc, psen_lo, rd_lo, wr_lo, ale_hi);
    checkOutput("wr_cycles", 32'(wr_lo), 32'(N));
    checkOutput("wr_psen_cycles", 32'(psen_lo), 32'd0);
    checkOutput("wr_rd_cycles", 32'(rd_lo), 32'd0);
    checkOutput("wr_data_kept", 32'(data_o), 32'h3C);
    wr_b = 1'b1;
    applyStimulus();

    // Write and ROM read together: write first, ROM read follows.
    $display("[TB] Priority");
    wr_b = 1'b0; rom_b = 1'b0; addr = 16'h1234; wdata = 8'h5A; p0_in = 8'h77;
    runUntilReady(cyc, psen_lo, rd_lo, wr_lo, ale_hi);
    checkOutput("prio_wr_cycles", 32'(wr_lo), 32'(N));
    checkOutput("prio_no_psen", 32'(psen_lo), 32'd0);
    wr_b = 1'b1;
    runUntilReady(cyc, psen_lo, rd_lo, wr_lo, ale_hi);
    checkOutput("prio_rom_gap", 32'(cyc), 32'(4 + N));
    checkOutput("prio_rom_psen", 32'(psen_lo), 32'(N));
    checkOutput("prio_rom_no_wr", 32'(wr_lo), 32'd0);
    checkOutput("prio_rom_data", 32'(data_o), 32'h77);
    rom_b = 1'b1;
    applyStimulus();

    // Back-to-back fetch FFFE then FFFF with rom_rd_b held low.
    $display("[TB] Back-to-back fetch");
    rom_b = 1'b0; addr = 16'hFFFE; p0_in = 8'h11;
    runUntilReady(cyc, psen_lo, rd_lo, wr_lo, ale_hi);
    checkOutput("b2b_first_data", 32'(data_o), 32'h11);
    addr = 16'hFFFF; p0_in = 8'h22;
    runUntilReady(cyc, psen_lo, rd_lo, wr_lo, ale_hi);
    checkOutput("b2b_spacing", 32'(cyc), 32'(4 + N));
    checkOutput("b2b_second_data", 32'(data_o), 32'h22);
    checkOutput("b2b_p2", 32'(p2_o), 32'hFF);
    rom_b = 1'b1;
    applyStimulus();

    // Reset during the second STRB cycle of a RAM read.
    $display("[TB] Reset mid-transaction");
    ram_rd_b = 1'b0; addr = 16'h4321; p0_in = 8'h99;
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("mid_rd_low", 32'(rd_b), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_rd_b", 32'(rd_b), 32'd1);
    checkOutput("mid_rst_p0_oe", 32'(p0_oe), 32'd0);
    checkOutput("mid_rst_ready", 32'(ready), 32'd0);
    checkOutput("mid_rst_data", 32'(data_o), 32'h00);
    modelReset();
    ram_rd_b = 1'b1;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    applyStimulus();
    applyStimulus();

    // EA_b follows the pad after two edges.
    ea_pad = 1'b0;
    applyStimulus();
    checkOutput("ea_one_edge", 32'(ea_b), 32'd1);
    applyStimulus();
    checkOutput("ea_two_edges", 32'(ea_b), 32'd0);
    ea_pad = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("ea_back_high", 32'(ea_b), 32'd1);

    // Randomized traffic with the handshake-respecting requester.
    $display("[TB] Random traffic");
    pending = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      driveRandom();
      applyStimulus();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
